pll_lock_sequencer: RTL
=======================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter STABLE_CYCLES, default 4096: consecutive synchronized-locked cycles required before the reset hold starts; range 1..65535.
REQ-002 Parameter HOLD_CYCLES, default 256: cycles sys_reset_n is held low after lock is stable; range 1..65535.
REQ-003 clk_49m  input  1  sole clock, 49.152 MHz PLL output; all logic on its rising edge.
REQ-004 reset_n  input  1  synchronous reset, active-low.
REQ-005 pll_locked  input  1  PLL locked flag, asynchronous to clk_49m.
REQ-006 pause  input  1  synchronous; suppresses CPU clock enables when high.
REQ-007 sys_reset_n  output  1  core reset, active-low, registered.
REQ-008 cen_6m  output  1  CPU enable, one-cycle pulse every 8 cycles (6.144 MHz), gated by pause.
REQ-009 cen_3m  output  1  CPU enable, one-cycle pulse every 16 cycles (3.072 MHz), gated by pause.
REQ-010 cen_snd  output  1  sound enable, one-cycle pulse every 32 cycles (1.536 MHz), not gated by pause.
REQ-011 seq_state  output  2  current state encoding: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
REQ-012 lock_loss_cnt  output  8  count of lock losses out of RUN, saturating at 255.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; lock_s denotes the second flop, giving 2 cycles of latency.
REQ-014 WAIT_LOCK: stay while lock_s=0; go to STABLE when lock_s=1, loading the 16-bit counter with 1.
REQ-015 STABLE: increment the counter while lock_s=1; go to HOLD and clear the counter when the counter = STABLE_CYCLES; go to WAIT_LOCK when lock_s=0.
REQ-016 HOLD: increment the counter; go to RUN when the counter = HOLD_CYCLES-1; go to WAIT_LOCK when lock_s=0.
REQ-017 RUN: stay while lock_s=1; go to WAIT_LOCK when lock_s=0.
REQ-018 Any lock_s=0 SHALL take priority over every counter-match transition in the same cycle.
REQ-019 sys_reset_n SHALL be registered as (next state = RUN), so it rises in the cycle seq_state first reads 3.
REQ-020 sys_reset_n SHALL fall in the cycle seq_state leaves RUN, i.e. 3 cycles after pll_locked falls.
REQ-021 A 5-bit divider SHALL be held at 0 outside RUN and increment by 1 per cycle in RUN, wrapping 31 to 0.
REQ-022 cen_6m, cen_3m and cen_snd SHALL be registered.
REQ-023 cen_6m first pulses on the 8th cycle after sys_reset_n rises; cen_3m first pulses on the 16th; cen_snd first pulses on the 32nd.
REQ-024 Every cen_3m pulse SHALL coincide with a cen_6m pulse, and every cen_snd pulse SHALL coincide with a cen_3m pulse (ungated).
REQ-025 When pause=1 at an edge, cen_6m and cen_3m SHALL be 0 in the following cycle.
REQ-026 pause SHALL NOT stop the divider and SHALL NOT affect cen_snd or the phase of any enable.
REQ-027 No enable SHALL pulse outside RUN, including in the first cycle after leaving RUN.
REQ-028 lock_loss_cnt SHALL increment on each RUN to WAIT_LOCK transition, saturating at 255; losses from STABLE or HOLD SHALL NOT count.

Reset
REQ-029 While reset_n=0 at an edge, the module SHALL set: state WAIT_LOCK, both synchronizer flops 0, counter 0, divider 0, lock_loss_cnt 0.
REQ-030 While reset_n=0 at an edge, the module SHALL set: sys_reset_n 0, all enables 0.
REQ-031 Reset mid-RUN SHALL drop sys_reset_n on the next edge, and the full sequence SHALL restart on release.

Structure
REQ-032 State encoding constants and the counter width (16) SHALL live in the shared core package.
REQ-033 The synchronizer SHALL be one sub-module, sync_2ff, reused elsewhere for asynchronous inputs.

Verification
REQ-034 STABLE_CYCLES=16, HOLD_CYCLES=4, pll_locked rises at cycle 10 and stays high -> sys_reset_n rises at cycle 10+2+16+4+1 (±1 per REQ-015/016 counting); cen_6m period 8; cen_snd period 32.
REQ-035 pll_locked low for 1 cycle in the middle of STABLE -> state returns to WAIT_LOCK, the stable count restarts, and lock_loss_cnt stays 0.
REQ-036 Lock lost in RUN -> sys_reset_n falls exactly 3 cycles after pll_locked falls; no enable after that point; lock_loss_cnt=1; 300 losses -> 255.
REQ-037 pause high for 20 cycles in RUN -> no cen_6m/cen_3m pulses during that window; cen_snd continues; after release cen_6m keeps its original phase (divider value 7).
REQ-038 reset_n low for 1 cycle during RUN -> outputs 0 next cycle, lock_loss_cnt 0, and the sequence repeats with identical timing.

Source files
------------

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared constants for the PLL lock sequencer: state encoding and counter widths.
package pll_lock_sequencer_pkg;
   localparam int CNT_W = 16;
   localparam int DIV_W = 5;

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_STABLE    = 2'd1;
   localparam logic [1:0] ST_HOLD      = 2'd2;
   localparam logic [1:0] ST_RUN       = 2'd3;
endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the core in reset until the PLL lock has been stable, then releases it
// and generates the CPU/sound clock enables from a divider that runs only in RUN.
module pll_lock_sequencer
   import pll_lock_sequencer_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4096,
   parameter int unsigned HOLD_CYCLES   = 256
) (
   input  logic       clk_49m,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       pause,
   output logic       sys_reset_n,
   output logic       cen_6m,
   output logic       cen_3m,
   output logic       cen_snd,
   output logic [1:0] seq_state,
   output logic [7:0] lock_loss_cnt
);
   localparam logic [CNT_W-1:0] STABLE_MATCH = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_MATCH   = CNT_W'(HOLD_CYCLES - 1);

   logic             lock_s;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       loss_q, loss_d;
   logic             sys_reset_n_q;
   logic             cen_6m_q, cen_3m_q, cen_snd_q;
   logic             run_d;

   sync_2ff u_lock_sync (
      .clk     (clk_49m),
      .reset_n (reset_n),
      .d       (pll_locked),
      .q       (lock_s)
   );

   // A dropped lock overrides every counter match, so it is tested first.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      loss_d  = loss_q;
      if (!lock_s) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = '0;
         if (state_q == ST_RUN && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
               state_d = ST_STABLE;
               cnt_d   = CNT_W'(1);
            end
            ST_STABLE: begin
               if (cnt_q == STABLE_MATCH) begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt_q == HOLD_MATCH) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   assign run_d = (state_d == ST_RUN);
   assign div_d = (state_q == ST_RUN) ? div_q + DIV_W'(1) : '0;

   // Enables are qualified by the next state so none can leak out of RUN.
   always_ff @(posedge clk_49m) begin
      if (!reset_n) begin
         state_q       <= ST_WAIT_LOCK;
         cnt_q         <= '0;
         div_q         <= '0;
         loss_q        <= '0;
         sys_reset_n_q <= 1'b0;
         cen_6m_q      <= 1'b0;
         cen_3m_q      <= 1'b0;
         cen_snd_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         div_q         <= div_d;
         loss_q        <= loss_d;
         sys_reset_n_q <= run_d;
         cen_6m_q      <= run_d && !pause && (div_q[2:0] == 3'b111);
         cen_3m_q      <= run_d && !pause && (div_q[3:0] == 4'hF);
         cen_snd_q     <= run_d && (&div_q);
      end
   end

   assign sys_reset_n   = sys_reset_n_q;
   assign cen_6m        = cen_6m_q;
   assign cen_3m        = cen_3m_q;
   assign cen_snd       = cen_snd_q;
   assign seq_state     = state_q;
   assign lock_loss_cnt = loss_q;
endmodule
